bias_add_6: RTL
===============

// Module: bias_add_6
// PURPOSE
//  Consumer end of the layer-6 bias stream. Pops `kern_s_k_6 coefficients from the bias ap_fifo into a
//  local store, then adds bias[ch] to each accumulator word from the conv-6 ap_fifo, channel-interleaved.
//  Writes the saturated sums to the downstream ap_fifo. Sits between bias_6 / the conv-6 MAC and the activation stage.
// PARAMETERS
//  N_CH       `kern_s_k_6    channels (biases per set); >=2
//  COEFF_W    `coeff_width   bias word width, signed two's complement
//  ACC_W      32             accumulator/output width, signed; ACC_W > COEFF_W
//  FRAME_PIX  0              pixels per frame; 0 = load biases once, >0 = reload after FRAME_PIX*N_CH outputs
// PORTS
//  ap_clk           in   1        clock, rising edge
//  ap_rst           in   1        asynchronous reset, active-high
//  bias_V_dout      in   COEFF_W  bias word, valid while bias_V_empty_n=1
//  bias_V_empty_n   in   1        bias FIFO not empty
//  bias_V_read      out  1        pop bias FIFO this cycle
//  acc_V_dout       in   ACC_W    accumulator word, valid while acc_V_empty_n=1
//  acc_V_empty_n    in   1        accumulator FIFO not empty
//  acc_V_read       out  1        pop accumulator FIFO this cycle
//  output_V_din     out  ACC_W    biased result
//  output_V_full_n  in   1        downstream FIFO not full
//  output_V_write   out  1        push output_V_din this cycle
// BEHAVIOUR
//  - Reset (async, ap_rst=1): state=LOAD, ld_cnt=0, ch=0, pix=0, out_vld=0, out_reg=0; all *_read/*_write=0,
//    output_V_din=0. Reset mid-frame drops partial bias set and in-flight result; store contents are don't-care.
//  - FSM LOAD: bias_V_read = bias_V_empty_n (combinational). On pop: store[ld_cnt]<=bias_V_dout, ld_cnt++.
//    On pop with ld_cnt==N_CH-1: ld_cnt<=0, ->RUN. acc_V_read=0 in LOAD. bias_V_read never 1 outside LOAD.
//  - FSM RUN: adv = !out_vld | output_V_full_n; acc_V_read = acc_V_empty_n & adv.
//    On pop: out_reg <= sat(sext(acc_V_dout) + sext(store[ch])), out_vld<=1, ch<=(ch==N_CH-1)?0:ch+1.
//    output_V_write = out_vld & output_V_full_n; output_V_din = out_reg. Write without pop -> out_vld<=0.
//    Simultaneous write and pop: register reloaded, out_vld stays 1 (full throughput, 1 word/cycle).
//  - Latency: acc pop at cycle t -> output_V_write earliest at t+1 (one register stage).
//  - Arithmetic: sum formed in ACC_W+1 bits; >2^(ACC_W-1)-1 -> MAX, < -2^(ACC_W-1) -> MIN; else truncate to ACC_W.
//  - Frame: pix++ when ch wraps N_CH-1->0. FRAME_PIX>0 and last pop of pixel FRAME_PIX-1: pix<=0, ->LOAD
//    once out_vld drains (LOAD may start while last result awaits full_n; that write still completes).
//  - output_V_full_n=0: out_reg held stable, no acc pops while out_vld=1. Empty inputs: no reads, state held.
//  - write/read strobes never asserted while corresponding full_n/empty_n=0.
// STRUCTURE
//  - `kern_s_k_6 from layers_sizes.vh, `coeff_width from my_types.vh; add ACC_MAX/ACC_MIN saturation
//    constants and LOAD/RUN state encoding to my_types.vh for reuse by bias_add_<n> of other layers.
//  - One sub-module: bias_store (N_CH x COEFF_W regs, 1 sync write port, 1 async read port by ch).
//  - Top: FSM, ld_cnt/ch/pix counters ($clog2 widths), sat adder, output register.
// TESTING  (bench: N_CH=4, COEFF_W=16, ACC_W=32, FRAME_PIX=2)
//  1 Biases {1,-2,3,-4} then acc {10,10,10,10} streamed, full_n=1 -> out {11,8,13,6}, first write 1 cycle after first acc pop.
//  2 acc {0x7FFFFFFF} with bias 3 -> out 0x7FFFFFFF; acc 0x80000000 with bias -4 -> out 0x80000000.
//  3 full_n=0 for 5 cycles with out_vld=1 -> output_V_din constant, acc_V_read=0, no write; release -> in-order, no loss/dup.
//  4 acc available before biases loaded (bias empty_n toggling 1010...) -> acc_V_read=0 until 4th bias popped.
//  5 After 8 outputs (2 pixels) -> returns to LOAD; new biases {100,0,0,0} -> next acc 5 gives 105.
//  6 ap_rst pulsed after 2 biases loaded -> all strobes 0 immediately; reload full set {1,-2,3,-4}, test 1 passes.

Source files
------------

// File: rtl/bias_add_6_pkg.sv
// Shared constants and state encoding for the bias_add_<n> layer blocks.
// Layer sizing mirrors layers_sizes.vh / my_types.vh.
package bias_add_6_pkg;

    localparam int unsigned KERN_S_K_6  = 4;
    localparam int unsigned COEFF_WIDTH = 16;
    localparam int unsigned ACC_WIDTH   = 32;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        StLoad,
        StRun
    } bias_state_e;

endpackage

// File: rtl/bias_store.sv
// Per-channel bias register file: one synchronous write port, one asynchronous read port.
module bias_store #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned IDX_W   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [COEFF_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    output logic [COEFF_W-1:0] rdata
);

    logic [COEFF_W-1:0] mem [N_CH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bias_add_6.sv
// Layer-6 bias adder: loads one bias per channel, then adds the channel's bias to each
// accumulator word with saturation and a single output register stage.
module bias_add_6
    import bias_add_6_pkg::*;
#(
    parameter int unsigned N_CH      = KERN_S_K_6,
    parameter int unsigned COEFF_W   = COEFF_WIDTH,
    parameter int unsigned ACC_W     = ACC_WIDTH,
    parameter int unsigned FRAME_PIX = 0
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   acc_V_dout,
    input  logic               acc_V_empty_n,
    output logic               acc_V_read,
    output logic [ACC_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);

    localparam int unsigned ChW    = $clog2(N_CH);
    localparam int unsigned PixN   = (FRAME_PIX > 0) ? FRAME_PIX : 1;
    localparam int unsigned PixW   = (PixN > 1) ? $clog2(PixN) : 1;
    localparam logic [ChW-1:0]  ChLast  = ChW'(N_CH - 1);
    localparam logic [PixW-1:0] PixLast = PixW'(PixN - 1);
    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    bias_state_e       state_q, state_d;
    logic [ChW-1:0]    ld_cnt_q, ld_cnt_d;
    logic [ChW-1:0]    ch_q, ch_d;
    logic [PixW-1:0]   pix_q, pix_d;
    logic              out_vld_q, out_vld_d;
    logic [ACC_W-1:0]  out_reg_q, out_reg_d;

    logic              store_we;
    logic [COEFF_W-1:0] bias_rd;
    logic [ACC_W:0]    acc_ext, bias_ext, sum;
    logic [ACC_W-1:0]  sat_val;
    logic              adv;

    bias_store #(
        .N_CH    (N_CH),
        .COEFF_W (COEFF_W),
        .IDX_W   (ChW)
    ) u_store (
        .clk   (ap_clk),
        .we    (store_we),
        .waddr (ld_cnt_q),
        .wdata (bias_V_dout),
        .raddr (ch_q),
        .rdata (bias_rd)
    );

    // Sum in ACC_W+1 bits; the top two bits disagree exactly on overflow.
    always_comb begin
        acc_ext  = {acc_V_dout[ACC_W-1], acc_V_dout};
        bias_ext = {{(ACC_W+1-COEFF_W){bias_rd[COEFF_W-1]}}, bias_rd};
        sum      = acc_ext + bias_ext;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat_val = sum[ACC_W] ? AccMin : AccMax;
        end else begin
            sat_val = sum[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        ch_d      = ch_q;
        pix_d     = pix_q;
        out_vld_d = out_vld_q;
        out_reg_d = out_reg_q;
        store_we  = 1'b0;
        bias_V_read = 1'b0;
        acc_V_read  = 1'b0;

        // Pending result drains in either state so LOAD can overlap the last write.
        output_V_write = out_vld_q & output_V_full_n & ~ap_rst;
        adv            = ~out_vld_q | output_V_full_n;
        if (output_V_write) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            StLoad: begin
                bias_V_read = bias_V_empty_n & ~ap_rst;
                if (bias_V_read) begin
                    store_we = 1'b1;
                    if (ld_cnt_q == ChLast) begin
                        ld_cnt_d = '0;
                        state_d  = StRun;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                acc_V_read = acc_V_empty_n & adv & ~ap_rst;
                if (acc_V_read) begin
                    out_reg_d = sat_val;
                    out_vld_d = 1'b1;
                    if (ch_q == ChLast) begin
                        ch_d = '0;
                        if (FRAME_PIX > 0 && pix_q == PixLast) begin
                            pix_d   = '0;
                            state_d = StLoad;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign output_V_din = out_reg_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= StLoad;
            ld_cnt_q  <= '0;
            ch_q      <= '0;
            pix_q     <= '0;
            out_vld_q <= 1'b0;
            out_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            ch_q      <= ch_d;
            pix_q     <= pix_d;
            out_vld_q <= out_vld_d;
            out_reg_q <= out_reg_d;
        end
    end

endmodule
